// File: rtl/fifo_bank_pkg.sv
// Shared constants and per-channel status type for the fifo_bank FIFO array.
// Optional error reporting in fifo_bank is enabled by defining FIFO_BANK_ERR_EN.
package fifo_bank_pkg;

    localparam int MAX_CHANNELS   = 16;
    localparam int STATUS_COUNT_W = 16;

    // count is carried at a fixed width so the type can be shared by every depth
    typedef struct packed {
        logic                      full;
        logic                      empty;
        logic                      almost_full;
        logic [STATUS_COUNT_W-1:0] count;
    } chan_status_t;

endpackage

// File: rtl/fifo_bank_channel.sv
// One circular-buffer FIFO channel; requests arrive already decoded for this channel.
// Storage is deliberately unreset: empty/count gating keeps stale entries unreadable.
module fifo_bank_channel
    import fifo_bank_pkg::*;
#(
    parameter int DATA_WIDTH        = 8,
    parameter int DEPTH_LOG2        = 4,
    parameter int ALMOST_FULL_LEVEL = (2**DEPTH_LOG2) - 1
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  push_req,
    input  logic                  pop_req,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic                  push_ok,
    output logic                  pop_ok,
    output logic [DATA_WIDTH-1:0] rd_data,
    output chan_status_t          status
);

    localparam int DEPTH = 2**DEPTH_LOG2;
    localparam int CNT_W = DEPTH_LOG2 + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  is_full;
    logic                  is_empty;

    assign is_full  = (count == CNT_W'(DEPTH));
    assign is_empty = (count == '0);

    // a full channel still takes a push when a pop frees a slot in the same cycle
    assign pop_ok  = pop_req && !is_empty;
    assign push_ok = push_req && (!is_full || pop_ok);

    assign rd_data = mem[rd_ptr];

    assign status = '{full:        is_full,
                      empty:       is_empty,
                      almost_full: (32'(count) >= ALMOST_FULL_LEVEL),
                      count:       STATUS_COUNT_W'(count)};

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fifo_bank.sv
// Bank of CHANNELS independent FIFOs with shared push/pop ports and a registered read port.
// Define FIFO_BANK_ERR_EN to add sticky overflow/underflow/addr_err flags and err_clear.
module fifo_bank
    import fifo_bank_pkg::*;
#(
    parameter int CHANNELS          = 4,
    parameter int DATA_WIDTH        = 8,
    parameter int DEPTH_LOG2        = 4,
    parameter int ALMOST_FULL_LEVEL = (2**DEPTH_LOG2) - 1,
    parameter int ADDR_WIDTH        = 4
) (
    input  logic                  clock,
    input  logic                  resetn,
`ifdef FIFO_BANK_ERR_EN
    input  logic                  err_clear,
    output logic [CHANNELS-1:0]   overflow,
    output logic [CHANNELS-1:0]   underflow,
    output logic                  addr_err,
`endif
    input  logic                  push,
    input  logic [ADDR_WIDTH-1:0] push_addr,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    input  logic [ADDR_WIDTH-1:0] pop_addr,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  pop_valid,
    output logic [CHANNELS-1:0]   full,
    output logic [CHANNELS-1:0]   empty,
    output logic [CHANNELS-1:0]   almost_full,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int LEVEL_W = DEPTH_LOG2 + 1;

    logic                  push_in_range;
    logic                  pop_in_range;
    logic [CHANNELS-1:0]   push_sel;
    logic [CHANNELS-1:0]   pop_sel;
    logic [CHANNELS-1:0]   push_req;
    logic [CHANNELS-1:0]   pop_req;
    logic [CHANNELS-1:0]   push_ok;
    logic [CHANNELS-1:0]   pop_ok;
    logic [DATA_WIDTH-1:0] rd_data [CHANNELS];
    chan_status_t          status  [CHANNELS];
    logic [DATA_WIDTH-1:0] sel_data;

    assign push_in_range = (32'(push_addr) < 32'(CHANNELS));
    assign pop_in_range  = (32'(pop_addr) < 32'(CHANNELS));

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        assign push_sel[g] = push_in_range && (push_addr == ADDR_WIDTH'(g));
        assign pop_sel[g]  = pop_in_range && (pop_addr == ADDR_WIDTH'(g));
        assign push_req[g] = push && push_sel[g];
        assign pop_req[g]  = pop && pop_sel[g];

        fifo_bank_channel #(
            .DATA_WIDTH        (DATA_WIDTH),
            .DEPTH_LOG2        (DEPTH_LOG2),
            .ALMOST_FULL_LEVEL (ALMOST_FULL_LEVEL)
        ) u_channel (
            .clock     (clock),
            .resetn    (resetn),
            .push_req  (push_req[g]),
            .pop_req   (pop_req[g]),
            .push_data (push_data),
            .push_ok   (push_ok[g]),
            .pop_ok    (pop_ok[g]),
            .rd_data   (rd_data[g]),
            .status    (status[g])
        );

        assign full[g]        = status[g].full;
        assign empty[g]       = status[g].empty;
        assign almost_full[g] = status[g].almost_full;
    end

    // at most one pop_ok bit is set, so this loop acts as a one-hot read mux
    always_comb begin
        sel_data = '0;
        level    = '0;
        for (int n = 0; n < CHANNELS; n++) begin
            if (pop_ok[n]) begin
                sel_data = rd_data[n];
            end
            if (pop_sel[n]) begin
                level = LEVEL_W'(status[n].count);
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            data_out  <= '0;
            pop_valid <= 1'b0;
        end else begin
            data_out  <= sel_data;
            pop_valid <= |pop_ok;
        end
    end

`ifdef FIFO_BANK_ERR_EN
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            overflow  <= '0;
            underflow <= '0;
            addr_err  <= 1'b0;
        end else if (err_clear) begin
            overflow  <= '0;
            underflow <= '0;
            addr_err  <= 1'b0;
        end else begin
            overflow  <= overflow | (push_req & ~push_ok);
            underflow <= underflow | (pop_req & ~pop_ok);
            addr_err  <= addr_err | (push && !push_in_range) | (pop && !pop_in_range);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_bank.sv
// Directed self-checking bench for fifo_bank (CHANNELS=4, DEPTH=16, DATA_WIDTH=8).
// Define FIFO_BANK_ERR_EN to also exercise the sticky error flags.
module tb_fifo_bank;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       push = 1'b0;
    logic [3:0] push_addr = 4'd0;
    logic [7:0] push_data = 8'd0;
    logic       pop = 1'b0;
    logic [3:0] pop_addr = 4'd0;
    logic [7:0] data_out;
    logic       pop_valid;
    logic [3:0] full;
    logic [3:0] empty;
    logic [3:0] almost_full;
    logic [4:0] level;
`ifdef FIFO_BANK_ERR_EN
    logic       err_clear = 1'b0;
    logic [3:0] overflow;
    logic [3:0] underflow;
    logic       addr_err;
`endif

    int total = 0;
    int bad   = 0;
    int next_in;
    int next_out;

    always #5 clock = ~clock;

    fifo_bank #(
        .CHANNELS   (4),
        .DATA_WIDTH (8),
        .DEPTH_LOG2 (4),
        .ADDR_WIDTH (4)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
`ifdef FIFO_BANK_ERR_EN
        .err_clear   (err_clear),
        .overflow    (overflow),
        .underflow   (underflow),
        .addr_err    (addr_err),
`endif
        .push        (push),
        .push_addr   (push_addr),
        .push_data   (push_data),
        .pop         (pop),
        .pop_addr    (pop_addr),
        .data_out    (data_out),
        .pop_valid   (pop_valid),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .level       (level)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // one clock of requests; pop_addr is left in place so level can be read afterwards
    task automatic applyStimulus(input logic do_push, input logic [3:0] paddr, input logic [7:0] pdata,
                                 input logic do_pop, input logic [3:0] oaddr);
        push      = do_push;
        push_addr = paddr;
        push_data = pdata;
        pop       = do_pop;
        pop_addr  = oaddr;
        @(posedge clock);
        #1;
        push = 1'b0;
        pop  = 1'b0;
    endtask

    initial begin
        $display("[TB] start");
        repeat (2) @(posedge clock);
        #1;
        checkOutput("rst_empty", 32'(empty), 'hF);
        checkOutput("rst_full", 32'(full), 'h0);
        checkOutput("rst_afull", 32'(almost_full), 'h0);
        checkOutput("rst_data", 32'(data_out), 'h0);
        checkOutput("rst_valid", 32'(pop_valid), 'h0);
        checkOutput("rst_level", 32'(level), 'h0);
        resetn = 1'b1;

        // fill channel 2 to the brim
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1'b1, 4'd2, 8'(i), 1'b0, 4'd2);
            if (i == 15) begin
                checkOutput("afull_at_15", 32'(almost_full), 'h4);
                checkOutput("not_full_at_15", 32'(full), 'h0);
            end
        end
        checkOutput("full_ch2", 32'(full), 'h4);
        checkOutput("empty_after_fill", 32'(empty), 'hB);
        checkOutput("level_full", 32'(level), 16);
        applyStimulus(1'b1, 4'd2, 8'd99, 1'b0, 4'd2);
        checkOutput("overpush_full", 32'(full), 'h4);
        checkOutput("overpush_level", 32'(level), 16);
`ifdef FIFO_BANK_ERR_EN
        checkOutput("overflow_set", 32'(overflow), 'h4);
`endif

        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1'b0, 4'd2, 8'd0, 1'b1, 4'd2);
            checkOutput("drain_data", 32'(data_out), 32'(i));
            checkOutput("drain_valid", 32'(pop_valid), 'h1);
        end
        checkOutput("drained_empty", 32'(empty), 'hF);
        applyStimulus(1'b0, 4'd2, 8'd0, 1'b1, 4'd2);
        checkOutput("empty_pop_data", 32'(data_out), 'h0);
        checkOutput("empty_pop_valid", 32'(pop_valid), 'h0);
`ifdef FIFO_BANK_ERR_EN
        checkOutput("underflow_set", 32'(underflow), 'h4);
        err_clear = 1'b1;
        @(posedge clock);
        #1;
        err_clear = 1'b0;
        checkOutput("clear_overflow", 32'(overflow), 'h0);
        checkOutput("clear_underflow", 32'(underflow), 'h0);
`endif

        // 40 values through channel 0, wrapping the pointers twice
        next_in  = 1;
        next_out = 1;
        for (int g = 0; g < 13; g++) begin
            for (int k = 0; k < 3; k++) begin
                applyStimulus(1'b1, 4'd0, 8'(next_in), 1'b0, 4'd0);
                next_in++;
            end
            for (int k = 0; k < 2; k++) begin
                applyStimulus(1'b0, 4'd0, 8'd0, 1'b1, 4'd0);
                checkOutput("wrap_order", 32'(data_out), 32'(next_out));
                next_out++;
            end
        end
        applyStimulus(1'b1, 4'd0, 8'(next_in), 1'b0, 4'd0);
        checkOutput("wrap_level", 32'(level), 14);
        for (int k = 0; k < 14; k++) begin
            applyStimulus(1'b0, 4'd0, 8'd0, 1'b1, 4'd0);
            checkOutput("wrap_tail", 32'(data_out), 32'(next_out));
            next_out++;
        end
        checkOutput("wrap_empty", 32'(empty), 'hF);

        // simultaneous push and pop on a full channel
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 4'd1, 8'(8'h10 + i), 1'b0, 4'd1);
        end
        applyStimulus(1'b1, 4'd1, 8'hAA, 1'b1, 4'd1);
        checkOutput("fullpp_data", 32'(data_out), 'h10);
        checkOutput("fullpp_full", 32'(full), 'h2);
        checkOutput("fullpp_level", 32'(level), 16);
        for (int i = 1; i < 16; i++) begin
            applyStimulus(1'b0, 4'd1, 8'd0, 1'b1, 4'd1);
            checkOutput("fullpp_order", 32'(data_out), 32'(8'h10 + i));
        end
        applyStimulus(1'b0, 4'd1, 8'd0, 1'b1, 4'd1);
        checkOutput("fullpp_last", 32'(data_out), 'hAA);

        // pop on an empty channel with same-cycle push: no bypass
        applyStimulus(1'b1, 4'd3, 8'h33, 1'b1, 4'd3);
        checkOutput("nobypass_valid", 32'(pop_valid), 'h0);
        checkOutput("nobypass_level", 32'(level), 1);
`ifdef FIFO_BANK_ERR_EN
        checkOutput("nobypass_underflow", 32'(underflow), 'h8);
        err_clear = 1'b1;
        @(posedge clock);
        #1;
        err_clear = 1'b0;
`endif

        applyStimulus(1'b1, 4'd0, 8'h44, 1'b1, 4'd3);
        checkOutput("cross_data", 32'(data_out), 'h33);
        checkOutput("cross_valid", 32'(pop_valid), 'h1);
        checkOutput("cross_empty", 32'(empty), 'hE);
        applyStimulus(1'b1, 4'd9, 8'h55, 1'b1, 4'd9);
        checkOutput("badaddr_valid", 32'(pop_valid), 'h0);
        checkOutput("badaddr_data", 32'(data_out), 'h0);
        checkOutput("badaddr_level", 32'(level), 'h0);
        checkOutput("badaddr_empty", 32'(empty), 'hE);
`ifdef FIFO_BANK_ERR_EN
        checkOutput("badaddr_err", 32'(addr_err), 'h1);
`endif
        applyStimulus(1'b0, 4'd0, 8'd0, 1'b0, 4'd0);
        checkOutput("badaddr_ch0_level", 32'(level), 1);

        // asynchronous reset with five entries queued in channel 0
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 4'd0, 8'(8'h45 + i), 1'b0, 4'd0);
        end
        pop      = 1'b1;
        pop_addr = 4'd0;
        @(posedge clock);
        #1;
        checkOutput("prereset_data", 32'(data_out), 'h44);
        checkOutput("prereset_level", 32'(level), 5);
        resetn = 1'b0;
        #1;
        checkOutput("async_empty", 32'(empty), 'hF);
        checkOutput("async_data", 32'(data_out), 'h0);
        checkOutput("async_valid", 32'(pop_valid), 'h0);
        checkOutput("async_level", 32'(level), 'h0);
        pop = 1'b0;
        @(posedge clock);
        #1;
        resetn = 1'b1;
        applyStimulus(1'b0, 4'd0, 8'd0, 1'b1, 4'd0);
        checkOutput("postreset_pop_valid", 32'(pop_valid), 'h0);
        applyStimulus(1'b1, 4'd0, 8'h77, 1'b0, 4'd0);
        applyStimulus(1'b0, 4'd0, 8'd0, 1'b1, 4'd0);
        checkOutput("postreset_data", 32'(data_out), 'h77);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_bank.md
FIFO_BANK -- requirements
Module: fifo_bank

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of independent FIFO channels (1..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, bits per entry.
REQ-003 SHALL have parameter DEPTH_LOG2, default 4, log2 of entries per channel (DEPTH = 2**DEPTH_LOG2).
REQ-004 SHALL have parameter ALMOST_FULL_LEVEL, default DEPTH-1, level at or above which almost_full asserts.
REQ-005 SHALL have parameter ADDR_WIDTH, default 4, channel address width.
REQ-006 Ports: clock  input  1  sole clock, all state updates on rising edge.
REQ-007 Ports: resetn  input  1  reset, asynchronous, active-low.
REQ-008 Ports: push / push_addr / push_data  input  1 / ADDR_WIDTH / DATA_WIDTH  write request, target channel, write data.
REQ-009 Ports: pop / pop_addr  input  1 / ADDR_WIDTH  read request, source channel.
REQ-010 Ports: data_out / pop_valid  output  DATA_WIDTH / 1  registered read data, and strobe marking it valid.
REQ-011 Ports: full / empty / almost_full  output  CHANNELS each  per-channel status, bit n = channel n.
REQ-012 Ports: level  output  DEPTH_LOG2+1  occupancy of channel pop_addr (0 when pop_addr out of range).

Function
REQ-013 Each channel SHALL be a circular buffer: write pointer, read pointer, count of DEPTH_LOG2+1 bits; pointers wrap DEPTH-1 -> 0; no data shifting.
REQ-014 full[n] SHALL equal (count==DEPTH), empty[n] (count==0), almost_full[n] (count>=ALMOST_FULL_LEVEL); all combinational from registers.
REQ-015 Push accepted when push=1, push_addr<CHANNELS and channel not full, or full with same-channel pop accepted the same cycle; entry written at write pointer, pointer advances.
REQ-016 Pop accepted when pop=1, pop_addr<CHANNELS and channel not empty; entry at read pointer appears on data_out the next cycle with pop_valid=1.
REQ-017 Cycles with no accepted pop SHALL drive data_out=0, pop_valid=0 on the next cycle.
REQ-018 Push and pop on different channels in the same cycle SHALL both proceed independently.
REQ-019 Push and pop on the same non-empty channel SHALL both proceed, count unchanged; valid when full.
REQ-020 Pop on an empty channel with same-cycle push SHALL reject the pop and accept the push; no bypass.
REQ-021 Rejected push (full, no same-channel pop) SHALL drop data, no state change; rejected pop SHALL leave channel unchanged.
REQ-022 Requests with address >= CHANNELS SHALL be ignored with no state change.
REQ-023 Data order per channel SHALL be strict FIFO across any number of pointer wraps.

Reset
REQ-024 resetn=0 SHALL immediately clear all pointers and counts, data_out=0, pop_valid=0, error flags=0; empty=all ones, full=almost_full=0.
REQ-025 Reset mid-operation SHALL discard all queued data; storage array is not reset and SHALL never be visible before being written.

Configuration
REQ-026 Macro FIFO_BANK_ERR_EN, when defined, SHALL add outputs overflow, underflow (CHANNELS each) and addr_err (1), plus input err_clear (1).
REQ-027 With FIFO_BANK_ERR_EN: rejected push sets overflow[n], rejected pop sets underflow[n], out-of-range address sets addr_err; sticky until err_clear=1 (clear wins over same-cycle set) or reset.
REQ-028 Without FIFO_BANK_ERR_EN: those ports and registers SHALL not exist; function otherwise identical.

Structure
REQ-029 Package fifo_bank_pkg SHALL hold max-channel constant and a typedef for per-channel status (full, empty, almost_full, count).
REQ-030 A sub-module fifo_bank_channel (one circular buffer, push/pop/status) SHALL be instantiated CHANNELS times via generate; fifo_bank holds decode and output mux/register.

Verification
REQ-031 Reset, then push 1..16 to channel 2 (DEPTH=16) -> full[2]=1, other bits 0; a 17th push (value 99) dropped, overflow[2]=1 if ERR_EN.
REQ-032 Pop channel 2 sixteen times -> data_out 1..16 one cycle after each pop with pop_valid=1; then empty[2]=1, extra pop gives data_out=0, pop_valid=0.
REQ-033 Push 40 values, popping after each 3 pushes, on channel 0 -> output order matches input across pointer wraps.
REQ-034 Full channel 1, same-cycle push 0xAA and pop -> oldest entry out, count stays 16, 0xAA last out.
REQ-035 Push channel 0 and pop channel 3 same cycle -> both succeed; pop_addr=9 (CHANNELS=4) -> no change, level=0, addr_err=1 if ERR_EN.
REQ-036 Assert resetn=0 mid-stream with 5 entries in channel 0 -> empty=all ones immediately, data_out=0, pop_valid=0.
